// File: rtl/mult_booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_booth_ctrl
//  Description : Control FSM for a radix-2 Booth sequential multiplier.
//                Sequences LOAD, N x (EVAL, SHIFT) and DONE. The outputs are
//                strobes that drive an external {HQ, LQ, Q-1} datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_ctrl #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] Q_LSB,
    output logic       load_A,
    output logic       load_B,
    output logic       clr_dp,
    output logic       load_add,
    output logic       add_sub,
    output logic       shift_HQ_LQ_Q_1,
    output logic       busy,
    output logic       done
);

    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // State and iteration counter registers; reset overrides start and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; abort only matters in LOAD/EVAL/SHIFT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = abort ? S_IDLE : S_EVAL;
            end
            S_EVAL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_EVAL;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from state and the Booth pair; forced low while in reset.
    always_comb begin
        load_A          = 1'b0;
        load_B          = 1'b0;
        clr_dp          = 1'b0;
        load_add        = 1'b0;
        add_sub         = 1'b0;
        shift_HQ_LQ_Q_1 = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        if (!rst) begin
            case (state_q)
                S_LOAD: begin
                    load_A = 1'b1;
                    load_B = 1'b1;
                    clr_dp = 1'b1;
                    busy   = 1'b1;
                end
                S_EVAL: begin
                    busy = 1'b1;
                    // 01 -> add M, 10 -> subtract M, 00/11 -> no change
                    case (Q_LSB)
                        2'b01: begin
                            load_add = 1'b1;
                            add_sub  = 1'b1;
                        end
                        2'b10: begin
                            load_add = 1'b1;
                            add_sub  = 1'b0;
                        end
                        default: begin
                            load_add = 1'b0;
                            add_sub  = 1'b0;
                        end
                    endcase
                end
                S_SHIFT: begin
                    shift_HQ_LQ_Q_1 = 1'b1;
                    busy            = 1'b1;
                end
                S_DONE: begin
                    done = 1'b1;
                    busy = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
